ram_mrnw_lvt: RTL and testbench
===============================

// Module: ram_mrnw_lvt
// PURPOSE
//  Parametrised multi-read / multi-write RAM built from NR x NW replicated 1R1W banks plus a
//  Live Value Table (LVT). Generalises the 16R1W replicated-read RAM to NW write ports.
//  Adds a post-reset zero-fill sweep, write-conflict arbitration and optional write-to-read bypass.
//  Sits as the shared register/scratch store between the issue stage and the functional units.
// PARAMETERS
//  NR      16  number of read ports (1..32)
//  NW      2   number of write ports (1..4); bank group per write port
//  DW      32  data width
//  AW      11  address width; depth = 2**AW
//  BYPASS  1   1: same-cycle read of a written address returns new data; 0: returns old data
// PORTS
//  clk         in   1      clock, all state on rising edge
//  rst         in   1      asynchronous, active-low reset
//  w_enb       in   NW     write enable per port
//  w_addr      in   NW*AW  write addresses, port k at [k*AW +: AW]
//  w_din       in   NW*DW  write data, port k at [k*DW +: DW]
//  r_addr      in   NR*AW  read addresses, port j at [j*AW +: AW]
//  r_dout      out  NR*DW  registered read data, port j at [j*DW +: DW]
//  ready       out  1      1 = init sweep done, ports live
//  w_conflict  out  1      registered pulse: >=2 enabled writes hit one address last cycle
// BEHAVIOUR
//  Reset (rst=0, async): r_dout=0, ready=0, w_conflict=0, FSM=INIT, sweep counter=0.
//  FSM INIT: each cycle write 0 to address cnt in every bank, LVT[cnt]=0, cnt++.
//   cnt==2**AW-1 -> RUN next edge; ready=1 from that edge. Init takes exactly 2**AW cycles.
//   In INIT: w_enb ignored, r_dout held 0, w_conflict held 0.
//  FSM RUN: stays until reset. rst low mid-operation returns to INIT and restarts the sweep.
//  Storage: bank[k][j] (k=write port, j=read port) written only by port k, read only by port j.
//  LVT: 2**AW entries x clog2(NW) bits (absent when NW=1); written with k on each write of port k.
//  Write: port k with w_enb[k]=1 at edge t updates bank[k][*][w_addr_k] and LVT.
//  Conflict: several enabled ports on one address -> highest k wins (only its LVT entry and its
//   banks written); w_conflict=1 for the cycle after edge t.
//  Read: r_addr_j sampled at edge t; r_dout_j = bank[LVT[a]][j][a], valid after edge t (1 cycle).
//  Write at edge t is visible to a read sampled at edge t+1 for every BYPASS value.
//  Same edge read+write, same address: BYPASS=1 -> winning w_din; BYPASS=0 -> pre-write value.
//  Address ports out of range are impossible (AW bits exact); no wrap needed.
//  Unused/disabled read ports still update r_dout every cycle (no read enable).
// TESTING (NR=4, NW=2, DW=32, AW=4 unless noted)
//  1 Reset release -> ready=0 for 16 cycles, ready=1 at cycle 16; all 16 addrs read 0x0.
//  2 W0 0xA5A5_0001@3, next cycle W1 0x0000_BEEF@3; read addr 3 on all 4 ports -> 0x0000_BEEF.
//  3 Same cycle W0 0x11@7, W1 0x22@7 -> w_conflict=1 next cycle; all ports read 0x22.
//  4 Write 0x55@9 with r_addr0=9 same edge: BYPASS=1 -> 0x55; BYPASS=0 -> old 0x0, then 0x55.
//  5 Four ports read 0,5,9,15 in one cycle after distinct writes -> each gets its own value.
//  6 rst low mid-stream after writes -> r_dout=0 at once; after re-sweep, former addrs read 0x0.

Source files
------------

// File: rtl/ram_mrnw_lvt.sv
// ---------------------------------------------------------------------------
// ram_mrnw_lvt
//   Multi-read / multi-write RAM. It is built from NW x NR replicated 1R1W
//   banks plus a Live Value Table (LVT). Each write port owns one bank group,
//   and each read port owns one bank in every group. The LVT records which
//   write port last wrote each address, and so selects which group to read.
//   After reset an INIT sweep writes zero to every address. Only then are the
//   ports live.
//
// Ports
//   clk         clock, all state on rising edge
//   rst         asynchronous, active-low reset
//   w_enb       [NW]      write enable per port
//   w_addr      [NW*AW]   write address, port k at [k*AW +: AW]
//   w_din       [NW*DW]   write data, port k at [k*DW +: DW]
//   r_addr      [NR*AW]   read address, port j at [j*AW +: AW]
//   r_dout      [NR*DW]   registered read data, port j at [j*DW +: DW]
//   ready       1 once the init sweep is done
//   w_conflict  registered pulse: >=2 enabled writes hit one address
// ---------------------------------------------------------------------------
module ram_mrnw_lvt #(
   parameter int NR     = 16,
   parameter int NW     = 2,
   parameter int DW     = 32,
   parameter int AW     = 11,
   parameter bit BYPASS = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NW-1:0]    w_enb,
   input  logic [NW*AW-1:0] w_addr,
   input  logic [NW*DW-1:0] w_din,
   input  logic [NR*AW-1:0] r_addr,
   output logic [NR*DW-1:0] r_dout,
   output logic             ready,
   output logic             w_conflict
);

   localparam int DEPTH = 2**AW;
   localparam int LW    = (NW > 1) ? $clog2(NW) : 1;

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] cnt;

   logic [DW-1:0] mem [NW][NR][DEPTH];

   logic [NW-1:0] wr_win;           // enabled and not overridden by a higher port
   logic          conflict_nxt;
   logic [NW-1:0] bank_we;
   logic [AW-1:0] bank_addr [NW];
   logic [DW-1:0] bank_data [NW];
   logic [LW-1:0] rd_sel    [NR];   // bank group holding the live value
   logic [DW-1:0] rd_data   [NR];

   // ---------------- control FSM ----------------
   // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_INIT) cnt <= cnt + 1'b1;
      end
   end

   // NOTE: combinational blocks assign defaults first, so no path leaves a signal unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT:  if (&cnt) state_nxt = S_RUN;
         S_RUN:   state_nxt = S_RUN;
         default: state_nxt = S_INIT;
      endcase
   end

   assign ready = (state == S_RUN);

   // ---------------- write arbitration ----------------
   // A port loses when any higher-numbered enabled port targets the same address.
   always_comb begin
      wr_win       = '0;
      conflict_nxt = 1'b0;
      for (int k = 0; k < NW; k++) begin
         wr_win[k] = w_enb[k];
         for (int m = k + 1; m < NW; m++) begin
            if (w_enb[k] && w_enb[m] &&
                w_addr[k*AW +: AW] == w_addr[m*AW +: AW]) begin
               wr_win[k]    = 1'b0;
               conflict_nxt = 1'b1;
            end
         end
      end
   end

   // While INIT is active, the sweep owns every bank write port.
   always_comb begin
      for (int k = 0; k < NW; k++) begin
         bank_we[k]   = wr_win[k];
         bank_addr[k] = w_addr[k*AW +: AW];
         bank_data[k] = w_din[k*DW +: DW];
         if (state == S_INIT) begin
            bank_we[k]   = 1'b1;
            bank_addr[k] = cnt;
            bank_data[k] = '0;
         end
      end
   end

   // ---------------- replicated banks ----------------
   // NOTE: the memory array has no reset; the INIT sweep clears it, which keeps it mappable to RAM.
   always_ff @(posedge clk) begin
      for (int k = 0; k < NW; k++)
         for (int j = 0; j < NR; j++)
            if (bank_we[k]) mem[k][j][bank_addr[k]] <= bank_data[k];
   end

   // ---------------- live value table ----------------
   generate
      if (NW > 1) begin : g_lvt
         logic [LW-1:0] lvt [DEPTH];

         always_ff @(posedge clk) begin
            for (int k = 0; k < NW; k++)
               if (bank_we[k]) lvt[bank_addr[k]] <= (state == S_INIT) ? '0 : LW'(k);
         end

         always_comb begin
            for (int j = 0; j < NR; j++) rd_sel[j] = lvt[r_addr[j*AW +: AW]];
         end
      end else begin : g_no_lvt
         always_comb begin
            for (int j = 0; j < NR; j++) rd_sel[j] = '0;
         end
      end
   endgenerate

   // ---------------- read path ----------------
   // With BYPASS set, a same-edge winning write to the read address forwards its data.
   // Otherwise the read returns the pre-write bank contents.
   always_comb begin
      for (int j = 0; j < NR; j++) begin
         rd_data[j] = mem[rd_sel[j]][j][r_addr[j*AW +: AW]];
         if (BYPASS) begin
            for (int k = 0; k < NW; k++)
               if (wr_win[k] && w_addr[k*AW +: AW] == r_addr[j*AW +: AW])
                  rd_data[j] = w_din[k*DW +: DW];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dout     <= '0;
         w_conflict <= 1'b0;
      end else if (state == S_INIT) begin
         r_dout     <= '0;
         w_conflict <= 1'b0;
      end else begin
         w_conflict <= conflict_nxt;
         for (int j = 0; j < NR; j++) r_dout[j*DW +: DW] <= rd_data[j];
      end
   end

endmodule

// File: tb/tb_ram_mrnw_lvt.sv
// ---------------------------------------------------------------------------
// tb_ram_mrnw_lvt
//   Drives two instances of ram_mrnw_lvt with identical stimulus: one with
//   BYPASS=1 and one with BYPASS=0. Both are compared against a flat
//   single-array memory model. In that model, a cycle's writes apply in
//   ascending port order, so the highest port wins.
// ---------------------------------------------------------------------------
module tb_ram_mrnw_lvt;

   localparam int NR    = 4;
   localparam int NW    = 2;
   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int DEPTH = 2**AW;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [NW-1:0]    w_enb  = '0;
   logic [NW*AW-1:0] w_addr = '0;
   logic [NW*DW-1:0] w_din  = '0;
   logic [NR*AW-1:0] r_addr = '0;
   logic [NR*DW-1:0] r_dout_b, r_dout_n;
   logic             ready_b, ready_n, conf_b, conf_n;

   always #5 clk = ~clk;

   ram_mrnw_lvt #(.NR(NR), .NW(NW), .DW(DW), .AW(AW), .BYPASS(1'b1)) dut_byp (
      .clk(clk), .rst(rst), .w_enb(w_enb), .w_addr(w_addr), .w_din(w_din),
      .r_addr(r_addr), .r_dout(r_dout_b), .ready(ready_b), .w_conflict(conf_b)
   );

   ram_mrnw_lvt #(.NR(NR), .NW(NW), .DW(DW), .AW(AW), .BYPASS(1'b0)) dut_nob (
      .clk(clk), .rst(rst), .w_enb(w_enb), .w_addr(w_addr), .w_din(w_din),
      .r_addr(r_addr), .r_dout(r_dout_n), .ready(ready_n), .w_conflict(conf_n)
   );

   int errors = 0;
   int checks = 0;

   // stimulus for the next edge
   logic [NW-1:0] we;
   logic [AW-1:0] wa [NW];
   logic [DW-1:0] wd [NW];
   logic [AW-1:0] ra [NR];

   // reference model
   logic [DW-1:0] model [DEPTH];
   int            init_left;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic randomize_ports(input int amax);
      we = NW'($urandom_range(0, 3));
      for (int k = 0; k < NW; k++) begin
         wa[k] = AW'($urandom_range(0, amax));
         wd[k] = $urandom;
      end
      for (int j = 0; j < NR; j++) ra[j] = AW'($urandom_range(0, amax));
   endtask

   // Apply one clock of stimulus and check both instances after the edge.
   task automatic step(input string tag);
      logic [DW-1:0] nxt   [DEPTH];
      logic [DW-1:0] e_byp [NR];
      logic [DW-1:0] e_old [NR];
      logic          e_conf;
      for (int k = 0; k < NW; k++) begin
         w_enb[k]           = we[k];
         w_addr[k*AW +: AW] = wa[k];
         w_din[k*DW +: DW]  = wd[k];
      end
      for (int j = 0; j < NR; j++) r_addr[j*AW +: AW] = ra[j];

      nxt    = model;
      e_conf = 1'b0;
      for (int j = 0; j < NR; j++) begin
         e_byp[j] = '0;
         e_old[j] = '0;
      end
      if (init_left == 0) begin
         for (int k = 0; k < NW; k++)
            if (we[k]) nxt[wa[k]] = wd[k];
         for (int a = 0; a < DEPTH; a++) begin
            int hits = 0;
            for (int k = 0; k < NW; k++)
               if (we[k] && int'(wa[k]) == a) hits++;
            if (hits > 1) e_conf = 1'b1;
         end
         for (int j = 0; j < NR; j++) begin
            e_byp[j] = nxt[ra[j]];
            e_old[j] = model[ra[j]];
         end
      end

      @(posedge clk);
      if (init_left > 0) init_left--;
      else               model = nxt;
      @(negedge clk);

      for (int j = 0; j < NR; j++) begin
         check($sformatf("%s byp rd%0d", tag, j), r_dout_b[j*DW +: DW], e_byp[j]);
         check($sformatf("%s nob rd%0d", tag, j), r_dout_n[j*DW +: DW], e_old[j]);
      end
      check($sformatf("%s byp conflict", tag), DW'(conf_b), DW'(e_conf));
      check($sformatf("%s nob conflict", tag), DW'(conf_n), DW'(e_conf));
      check($sformatf("%s byp ready", tag), DW'(ready_b), DW'(init_left == 0));
      check($sformatf("%s nob ready", tag), DW'(ready_n), DW'(init_left == 0));
   endtask

   // Called at a negedge: assert reset mid-low-phase, check outputs clear at once,
   // then release it at the next negedge.
   task automatic do_reset(input string tag);
      #2 rst = 1'b0;
      #1;
      check($sformatf("%s byp dout", tag), r_dout_b[DW-1:0] | r_dout_b[NR*DW-1:DW*(NR-1)], '0);
      check($sformatf("%s nob dout", tag), r_dout_n[DW-1:0] | r_dout_n[NR*DW-1:DW*(NR-1)], '0);
      check($sformatf("%s byp ready", tag), DW'(ready_b), '0);
      check($sformatf("%s byp conflict", tag), DW'(conf_b), '0);
      for (int a = 0; a < DEPTH; a++) model[a] = '0;
      init_left = DEPTH;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic sweep_and_read_all(input string tag);
      // Enables and addresses toggle during INIT; the DUT must ignore them.
      for (int i = 0; i < DEPTH; i++) begin
         randomize_ports(DEPTH - 1);
         step($sformatf("%s init%0d", tag, i));
      end
      we = '0;
      for (int b = 0; b < DEPTH / NR; b++) begin
         for (int j = 0; j < NR; j++) ra[j] = AW'(b * NR + j);
         step($sformatf("%s zero%0d", tag, b));
      end
   endtask

   initial begin
      we = '0;
      for (int k = 0; k < NW; k++) begin wa[k] = '0; wd[k] = '0; end
      for (int j = 0; j < NR; j++) ra[j] = '0;
      for (int a = 0; a < DEPTH; a++) model[a] = '0;
      init_left = DEPTH;

      @(negedge clk);
      do_reset("rst1");
      sweep_and_read_all("t1");

      // port 1 overwrites port 0's earlier value
      we = 2'b01; wa[0] = 4'd3; wd[0] = 32'hA5A5_0001;
      for (int j = 0; j < NR; j++) ra[j] = 4'd3;
      step("t2a");
      we = 2'b10; wa[1] = 4'd3; wd[1] = 32'h0000_BEEF;
      step("t2b");
      we = 2'b00;
      step("t2c");

      // same-cycle conflict: the highest port wins
      we = 2'b11; wa[0] = 4'd7; wa[1] = 4'd7; wd[0] = 32'h11; wd[1] = 32'h22;
      for (int j = 0; j < NR; j++) ra[j] = 4'd7;
      step("t3a");
      we = 2'b00;
      step("t3b");

      // same-edge read of a written address
      we = 2'b01; wa[0] = 4'd9; wd[0] = 32'h55;
      ra[0] = 4'd9; ra[1] = 4'd1; ra[2] = 4'd2; ra[3] = 4'd9;
      step("t4a");
      we = 2'b00;
      step("t4b");

      // distinct addresses, each port reads its own value
      we = 2'b11; wa[0] = 4'd0; wd[0] = 32'h1000_0000; wa[1] = 4'd5; wd[1] = 32'h2000_0005;
      step("t5a");
      wa[0] = 4'd9; wd[0] = 32'h3000_0009; wa[1] = 4'd15; wd[1] = 32'h4000_000F;
      step("t5b");
      we = 2'b00; ra[0] = 4'd0; ra[1] = 4'd5; ra[2] = 4'd9; ra[3] = 4'd15;
      step("t5c");

      // random traffic concentrated on a few addresses to force conflicts and bypass hits
      for (int i = 0; i < 400; i++) begin
         randomize_ports((i % 3 == 0) ? DEPTH - 1 : 5);
         step($sformatf("rnd%0d", i));
      end

      // mid-stream reset, then every address reads zero again
      do_reset("rst2");
      sweep_and_read_all("t6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
